// File: rtl/maga_cmd_tx.sv
// Command-frame transmitter toward the MAGA magnetometer.
// Sends {HEADER, CMD, ARG_HI, ARG_LO, CHK} byte-by-byte into the UART core
// using its TXRDY / active-low WEN handshake, gated by MAGA_READY.
// Aborts on device fault or on a per-byte handshake timeout.
module maga_cmd_tx #(
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter int unsigned SETTLE  = 2,        // 1..15
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        START,
  input  logic [7:0]  CMD,
  input  logic [15:0] ARG,
  input  logic        MAGA_READY,
  input  logic        MAGA_FLT,
  input  logic        TXrd,
  output logic [7:0]  TX,
  output logic        WEN,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [1:0]  ERR_CODE
);

  localparam logic [3:0]  SettleLast  = 4'(SETTLE - 1);
  localparam logic [15:0] TimeoutLast = TIMEOUT - 16'd1;
  localparam logic [1:0]  CodeNone    = 2'b00;
  localparam logic [1:0]  CodeFault   = 2'b01;
  localparam logic [1:0]  CodeTimeout = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRdy,
    StWrite,
    StSettle,
    StFinish
  } state_e;

  state_e      state_q;
  logic [2:0]  idx_q;
  logic [15:0] timer_q;
  logic [3:0]  settle_q;
  logic [7:0]  cmd_q;
  logic [15:0] arg_q;
  logic [7:0]  chk_q;
  logic [7:0]  tx_q;
  logic        wen_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [1:0]  err_code_q;
  logic [7:0]  frame_byte;

  // Select the frame byte addressed by the current index.
  always_comb begin
    frame_byte = HEADER;
    case (idx_q)
      3'd0:    frame_byte = HEADER;
      3'd1:    frame_byte = cmd_q;
      3'd2:    frame_byte = arg_q[15:8];
      3'd3:    frame_byte = arg_q[7:0];
      default: frame_byte = chk_q;
    endcase
  end

  // Frame sequencer; all outputs are registered alongside the state so that
  // WEN is low exactly while the FSM sits in StWrite.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= StIdle;
      idx_q      <= 3'd0;
      timer_q    <= 16'd0;
      settle_q   <= 4'd0;
      cmd_q      <= 8'h00;
      arg_q      <= 16'h0000;
      chk_q      <= 8'h00;
      tx_q       <= 8'h00;
      wen_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= CodeNone;
    end else begin
      // Pulses default to inactive; TX holds its last byte.
      wen_q  <= 1'b1;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (START) begin
            cmd_q      <= CMD;
            arg_q      <= ARG;
            chk_q      <= HEADER + CMD + ARG[15:8] + ARG[7:0];
            idx_q      <= 3'd0;
            timer_q    <= 16'd0;
            busy_q     <= 1'b1;
            err_code_q <= CodeNone;
            state_q    <= StWaitRdy;
          end
        end
        StWaitRdy: begin
          if (MAGA_FLT) begin
            err_q      <= 1'b1;
            err_code_q <= CodeFault;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
          end else if (timer_q == TimeoutLast) begin
            err_q      <= 1'b1;
            err_code_q <= CodeTimeout;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
          end else if (TXrd && MAGA_READY) begin
            wen_q   <= 1'b0;
            tx_q    <= frame_byte;
            state_q <= StWrite;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        // The byte is already on the bus; a fault here is only seen in StSettle.
        StWrite: begin
          settle_q <= 4'd0;
          state_q  <= StSettle;
        end
        StSettle: begin
          if (MAGA_FLT) begin
            err_q      <= 1'b1;
            err_code_q <= CodeFault;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
          end else if (settle_q == SettleLast) begin
            if (idx_q == 3'd4) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StFinish;
            end else begin
              idx_q   <= idx_q + 3'd1;
              timer_q <= 16'd0;
              state_q <= StWaitRdy;
            end
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        StFinish: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign TX       = tx_q;
  assign WEN      = wen_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign ERR_CODE = err_code_q;

endmodule

// File: tb/tb_maga_cmd_tx.sv
// Scoreboard bench for maga_cmd_tx: stimulus pushes expected frame bytes,
// a negedge monitor pops and compares on every WEN pulse.
module tb_maga_cmd_tx;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_a, start_b;
  logic [7:0]  cmd;
  logic [15:0] arg;
  logic        ready_a, ready_b, flt, txrd;

  logic [7:0]  tx_a, tx_b;
  logic        wen_a, busy_a, done_a, err_a;
  logic        wen_b, busy_b, done_b, err_b;
  logic [1:0]  code_a, code_b;

  always #5 clk = ~clk;

  maga_cmd_tx #(.HEADER(8'hA5), .SETTLE(2), .TIMEOUT(16'd50000)) u_dut (
    .CLK(clk), .RESETN(rstn), .START(start_a), .CMD(cmd), .ARG(arg),
    .MAGA_READY(ready_a), .MAGA_FLT(flt), .TXrd(txrd),
    .TX(tx_a), .WEN(wen_a), .BUSY(busy_a), .DONE(done_a), .ERR(err_a), .ERR_CODE(code_a)
  );

  // Short-timeout instance used only for the timeout scenario.
  maga_cmd_tx #(.HEADER(8'hA5), .SETTLE(2), .TIMEOUT(16'd16)) u_dut_to (
    .CLK(clk), .RESETN(rstn), .START(start_b), .CMD(cmd), .ARG(arg),
    .MAGA_READY(ready_b), .MAGA_FLT(1'b0), .TXrd(1'b1),
    .TX(tx_b), .WEN(wen_b), .BUSY(busy_b), .DONE(done_b), .ERR(err_b), .ERR_CODE(code_b)
  );

  int checks = 0;
  int errors = 0;
  int pcyc = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int wen_t[$];
  int wen_cnt_a = 0, wen_cnt_b = 0;
  int done_cnt = 0, err_cnt = 0, err_cnt_b = 0, done_cnt_b = 0;
  int done_t = 0, err_t_b = 0;
  logic prev_wen_a = 1'b1, prev_wen_b = 1'b1;

  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, pcyc);
    end
  endtask

  // Monitor: compare every written byte against the scoreboard.
  always @(negedge clk) begin
    if (rstn) begin
      if (!wen_a) begin
        check("wen_a_not_back_to_back", prev_wen_a, 1);
        wen_cnt_a++;
        wen_t.push_back(pcyc);
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_a_unexpected: got %02h want no byte", tx_a);
        end else begin
          check("tx_a_byte", tx_a, exp_a.pop_front());
        end
      end
      if (!wen_b) begin
        check("wen_b_not_back_to_back", prev_wen_b, 1);
        wen_cnt_b++;
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_b_unexpected: got %02h want no byte", tx_b);
        end else begin
          check("tx_b_byte", tx_b, exp_b.pop_front());
        end
      end
      if (done_a) begin done_cnt++; done_t = pcyc; end
      if (err_a) err_cnt++;
      if (done_b) done_cnt_b++;
      if (err_b) begin err_cnt_b++; err_t_b = pcyc; end
    end
    prev_wen_a = wen_a;
    prev_wen_b = wen_b;
  end

  // Issue START on instance A; s is the cycle of the sampling edge.
  task automatic send_a(input logic [7:0] c, input logic [15:0] a, input logic [7:0] chk,
                        output int s);
    exp_a.push_back(8'hA5); exp_a.push_back(c); exp_a.push_back(a[15:8]);
    exp_a.push_back(a[7:0]); exp_a.push_back(chk);
    wen_t.delete();
    @(posedge clk); #1;
    cmd = c; arg = a; start_a = 1'b1;
    @(posedge clk); #1;
    s = pcyc;
    start_a = 1'b0;
  endtask

  task automatic wait_end_a(input int budget, input string name);
    int n = 0;
    int base = done_cnt + err_cnt;
    while (done_cnt + err_cnt == base && n < budget) begin
      @(posedge clk); #1; n++;
    end
    if (done_cnt + err_cnt == base) begin
      checks++; errors++;
      $display("FAIL %s: no DONE/ERR within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_wen(input bit sel_b, input int target, input string name);
    int n = 0;
    while ((sel_b ? wen_cnt_b : wen_cnt_a) < target && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if ((sel_b ? wen_cnt_b : wen_cnt_a) < target) begin
      checks++; errors++;
      $display("FAIL %s: got %0d WEN pulses want %0d", name, sel_b ? wen_cnt_b : wen_cnt_a,
               target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, r, base, n, d0, e0;
    rstn = 1'b0; start_a = 1'b0; start_b = 1'b0; cmd = 8'h00; arg = 16'h0000;
    ready_a = 1'b1; ready_b = 1'b1; flt = 1'b0; txrd = 1'b1;

    // Reset values.
    #23;
    check("rst_tx", tx_a, 8'h00);
    check("rst_wen", wen_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_err", err_a, 0);
    check("rst_code", code_a, 0);
    @(posedge clk); #1; rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Basic frame and cycle-exact latency.
    send_a(8'h12, 16'h3456, 8'h41, s);
    wait_end_a(100, "frame1_end");
    check("frame1_done", done_cnt, 1);
    check("frame1_err", err_cnt, 0);
    check("frame1_left", exp_a.size(), 0);
    check("frame1_done_time", done_t - s, 20);
    check("frame1_wen_count", wen_t.size(), 5);
    if (wen_t.size() == 5) begin
      check("frame1_first_wen", wen_t[0] - s, 1);
      for (int i = 1; i < 5; i++) check("frame1_wen_spacing", wen_t[i] - wen_t[i-1], 4);
    end
    check("frame1_busy_after", busy_a, 0);

    // Wraparound checksum, plus a START while busy that must be ignored.
    send_a(8'hFF, 16'hFFFF, 8'hA2, s);
    repeat (5) @(posedge clk);
    #1;
    check("ignore_busy", busy_a, 1);
    cmd = 8'h77; arg = 16'h0000; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    wait_end_a(100, "frame2_end");
    check("frame2_done", done_cnt, 2);
    check("frame2_left", exp_a.size(), 0);
    check("frame2_wen_count", wen_cnt_a, 10);
    repeat (10) @(posedge clk);
    #1;
    check("frame2_no_extra_wen", wen_cnt_a, 10);
    check("frame2_idle", busy_a, 0);

    // Backpressure before byte 2.
    base = wen_cnt_a;
    send_a(8'h01, 16'h0203, 8'hAB, s);
    wait_wen(1'b0, base + 2, "bp_first_two");
    txrd = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("bp_wen_held", wen_cnt_a, base + 2);
    check("bp_still_busy", busy_a, 1);
    txrd = 1'b1;
    r = pcyc;
    wait_end_a(100, "bp_end");
    check("bp_done", done_cnt, 3);
    check("bp_err", err_cnt, 0);
    check("bp_code", code_a, 0);
    if (wen_t.size() > 2) check("bp_resume_time", wen_t[2] - r, 1);
    else check("bp_wen_count", wen_t.size(), 5);

    // Timeout on the short-timeout instance after byte 0.
    exp_b.push_back(8'hA5); exp_b.push_back(8'hC3); exp_b.push_back(8'h00);
    exp_b.push_back(8'h00); exp_b.push_back(8'h68);
    @(posedge clk); #1;
    cmd = 8'hC3; arg = 16'h0000; start_b = 1'b1;
    @(posedge clk); #1;
    s = pcyc; start_b = 1'b0;
    wait_wen(1'b1, 1, "to_first_byte");
    ready_b = 1'b0;
    n = 0;
    while (err_cnt_b == 0 && n < 100) begin @(posedge clk); #1; n++; end
    check("to_err", err_cnt_b, 1);
    check("to_code", code_b, 2);
    check("to_err_time", err_t_b - s, 20);
    check("to_wen_count", wen_cnt_b, 1);
    check("to_busy", busy_b, 0);
    check("to_no_done", done_cnt_b, 0);
    check("to_abandoned", exp_b.size(), 4);
    exp_b.delete();
    ready_b = 1'b1;

    // Fault during SETTLE after byte 3 (index 2).
    base = wen_cnt_a;
    e0 = err_cnt;
    send_a(8'h20, 16'h1122, 8'hF8, s);
    wait_wen(1'b0, base + 3, "flt_three_bytes");
    flt = 1'b1;
    wait_end_a(20, "flt_end");
    flt = 1'b0;
    check("flt_err", err_cnt, e0 + 1);
    check("flt_code", code_a, 1);
    check("flt_busy", busy_a, 0);
    check("flt_abandoned", exp_a.size(), 2);
    exp_a.delete();
    repeat (10) @(posedge clk);
    #1;
    check("flt_wen_count", wen_cnt_a, base + 3);
    check("flt_code_held", code_a, 1);
    d0 = done_cnt;
    send_a(8'h33, 16'h0000, 8'hD8, s);
    check("flt_code_cleared", code_a, 0);
    check("flt_restart_busy", busy_a, 1);
    wait_end_a(100, "flt_restart_end");
    check("flt_restart_done", done_cnt, d0 + 1);
    check("flt_restart_left", exp_a.size(), 0);

    // Asynchronous reset while WEN is low mid-frame.
    base = wen_cnt_a;
    send_a(8'h5A, 16'hA55A, 8'hFE, s);
    wait_wen(1'b0, base + 2, "rst_two_bytes");
    repeat (3) @(posedge clk);
    #2;
    check("rst_pre_wen_low", wen_a, 0);
    rstn = 1'b0;
    #1;
    check("rst_async_wen", wen_a, 1);
    check("rst_async_tx", tx_a, 8'h00);
    check("rst_async_busy", busy_a, 0);
    exp_a.delete();
    d0 = done_cnt; e0 = err_cnt; base = wen_cnt_a;
    repeat (2) @(posedge clk);
    #1; rstn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("rst_no_wen", wen_cnt_a, base);
    check("rst_no_done", done_cnt, d0);
    check("rst_no_err", err_cnt, e0);
    check("rst_code_after", code_a, 0);
    check("rst_busy_after", busy_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
